// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle execution controller:
// opcode and ALU-op encodings, sequencer states, instruction field
// positions and small decode helpers.
package mc_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned RX_LSB  = 9;
  localparam int unsigned RY_LSB  = 6;
  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned IMM_W   = 9;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_OR  = 4'h2;
  localparam logic [3:0] OP_SLT = 4'h3;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRL = 4'h5;
  localparam logic [3:0] OP_LDI = 4'h6;
  localparam logic [3:0] OP_MV  = 4'h7;

  localparam logic [2:0] ULA_ADD = 3'b000;
  localparam logic [2:0] ULA_SUB = 3'b001;
  localparam logic [2:0] ULA_OR  = 3'b010;
  localparam logic [2:0] ULA_SLT = 3'b011;
  localparam logic [2:0] ULA_SLL = 3'b100;
  localparam logic [2:0] ULA_SRL = 3'b101;

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return op <= OP_SRL;
  endfunction

  function automatic logic is_illegal_op(input logic [3:0] op);
    return op[3];
  endfunction

  function automatic logic [2:0] to_ula(input logic [3:0] op);
    logic [2:0] u;
    case (op)
      OP_ADD:  u = ULA_ADD;
      OP_SUB:  u = ULA_SUB;
      OP_OR:   u = ULA_OR;
      OP_SLT:  u = ULA_SLT;
      OP_SLL:  u = ULA_SLL;
      OP_SRL:  u = ULA_SRL;
      default: u = ULA_ADD;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/mc_exec_ctrl_if.sv
// Run/done handshake between the instruction source and the sequencer.
//   run      : start request (source -> sequencer)
//   instr    : instruction word, sampled on the accepting edge
//   busy     : sequencer is not idle
//   done     : one-cycle completion pulse
//   illegal  : qualifies done when the opcode was undefined
interface mc_exec_ctrl_if;
  import mc_pkg::*;

  logic               run;
  logic [INSTR_W-1:0] instr;
  logic               busy;
  logic               done;
  logic               illegal;

  modport master (output run, instr, input busy, done, illegal);
  modport slave  (input run, instr, output busy, done, illegal);
endinterface

// File: rtl/mc_regfile.sv
// 8x16 register file: one synchronous write port, two combinational
// operand read ports and a combinational debug read port. All registers
// clear on the asynchronous active-low reset.
module mc_regfile #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_ADDR_W = 3
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0]     rdata_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0]     rdata_b,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
);
  localparam int unsigned NREG = 1 << REG_ADDR_W;

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_addr];
endmodule

// File: rtl/mc_exec_ctrl.sv
// Multi-cycle instruction sequencer sitting in front of an external ALU.
//   clock, resetn        : clock and asynchronous active-low reset
//   ctl (slave)          : run/instr in, busy/done/illegal out
//   ula_a, ula_b, ula_op : ALU operands/op, driven only in EXEC, else 0
//   ula_out              : combinational ALU result
//   dbg_addr, dbg_data   : combinational register read-back
// Sequence: IDLE -> DECODE -> (EXEC) -> WB -> IDLE.
module mc_exec_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_ADDR_W = 3
) (
  input  logic                  clock,
  input  logic                  resetn,
  mc_exec_ctrl_if.slave         ctl,
  output logic [DATA_W-1:0]     ula_a,
  output logic [DATA_W-1:0]     ula_b,
  output logic [2:0]            ula_op,
  input  logic [DATA_W-1:0]     ula_out,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
);
  state_t             state;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  a_q, b_q, g_q;
  logic [DATA_W-1:0]  rd_a, rd_b;
  logic [DATA_W-1:0]  wdata;
  logic               we;

  logic [OPC_W-1:0]      opc;
  logic [REG_ADDR_W-1:0] rx, ry;
  logic [IMM_W-1:0]      imm9;

  assign opc  = ir[OPC_LSB +: OPC_W];
  assign rx   = ir[RX_LSB +: REG_ADDR_W];
  assign ry   = ir[RY_LSB +: REG_ADDR_W];
  assign imm9 = ir[IMM_LSB +: IMM_W];

  mc_regfile #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_regfile (
    .clock    (clock),
    .resetn   (resetn),
    .we       (we),
    .waddr    (rx),
    .wdata    (wdata),
    .raddr_a  (rx),
    .rdata_a  (rd_a),
    .raddr_b  (ry),
    .rdata_b  (rd_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      ir    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      g_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ctl.run) begin
            ir    <= ctl.instr;
            state <= DECODE;
          end
        end
        DECODE: begin
          a_q   <= rd_a;
          b_q   <= rd_b;
          state <= is_alu_op(opc) ? EXEC : WB;
        end
        EXEC: begin
          g_q   <= ula_out;
          state <= WB;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The illegal flag is decoded from the held IR rather than stored:
  // IR is stable from DECODE through WB, so this matches a DECODE-time flag.
  assign we = (state == WB) && !is_illegal_op(opc);

  always_comb begin
    wdata = g_q;
    case (opc)
      OP_LDI:  wdata = {{(DATA_W-IMM_W){1'b0}}, imm9};
      OP_MV:   wdata = b_q;
      default: wdata = g_q;
    endcase
  end

  assign ctl.busy    = (state != IDLE);
  assign ctl.done    = (state == WB);
  assign ctl.illegal = (state == WB) && is_illegal_op(opc);

  assign ula_a  = (state == EXEC) ? a_q : '0;
  assign ula_b  = (state == EXEC) ? b_q : '0;
  assign ula_op = (state == EXEC) ? to_ula(opc) : '0;
endmodule
